pixel_upscale_2x: RTL and testbench
===================================

PIXEL_UPSCALE_2X -- requirements
Module: pixel_upscale_2x

Interface
REQ-001 SHALL have parameter SRC_W, default 225, source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 225, source image height in lines.
REQ-003 SHALL have parameter DW, default 8, pixel data width.
REQ-004 SHALL have port clk  input  1  single clock for the whole block; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_vsync  input  1  display vertical sync, active-low.
REQ-007 SHALL have port i_next  input  1  display requests one output pixel this cycle (450x450 window).
REQ-008 SHALL have port o_src_req  output  1  one-cycle pull of the next source pixel from upstream loader.
REQ-009 SHALL have port i_src_data  input  DW  source pixel, sampled the cycle after o_src_req.
REQ-010 SHALL have port i_src_valid  input  1  qualifies i_src_data, expected high the cycle after o_src_req.
REQ-011 SHALL have port o_data  output  DW  upscaled pixel to the DVI stage.
REQ-012 SHALL have port o_valid  output  1  qualifies o_data.
REQ-013 SHALL have port o_underflow  output  1  sticky flag: source missed a requested pixel this frame.

Function
REQ-014 SHALL keep output counters col (0..2*SRC_W-1) and row (0..2*SRC_H-1), each advancing only on accepted i_next cycles.
REQ-015 SHALL advance col by 1 on every accepted i_next cycle; at 2*SRC_W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-016 SHALL hold col and row when i_next is low mid-row, resuming at the same position.
REQ-017 SHALL use states IDLE, EVEN, ODD, DONE; reset -> IDLE.
REQ-018 SHALL leave IDLE, DONE or any state on a falling edge of i_vsync (registered detect), going to EVEN with col=0, row=0 and o_underflow cleared.
REQ-019 SHALL go EVEN->ODD and ODD->EVEN at each row wrap; ODD->DONE when row 2*SRC_H-1 wraps.
REQ-020 SHALL, in EVEN, assert o_src_req combinationally in the same cycle as an accepted i_next with col even; never with col odd.
REQ-021 SHALL, in EVEN, write the received source pixel into a SRC_W x DW line buffer at address col>>1 the cycle after the request.
REQ-022 SHALL, in ODD, never assert o_src_req and read the line buffer at address col>>1 (synchronous read).
REQ-023 SHALL produce o_data/o_valid for the i_next accepted in cycle t at cycle t+2 (fixed latency 2, both rows).
REQ-024 SHALL output the same source pixel for columns 2k and 2k+1 (horizontal duplication) and the same line for rows 2m and 2m+1 (vertical duplication).
REQ-025 SHALL, if i_src_valid is low the cycle after o_src_req, output 0 for both pixels of that pair, write 0 to the line buffer and set o_underflow.
REQ-026 SHALL ignore i_next in IDLE and DONE: no o_src_req, o_valid=0, counters unchanged.
REQ-027 SHALL give a vsync falling edge priority over a coincident i_next: that i_next is not accepted, produces no output, in-flight pipeline outputs are dropped.
REQ-028 SHALL drive o_data=0 whenever o_valid=0.

Reset
REQ-029 SHALL, while rst is high, force o_valid=0, o_data=0, o_src_req=0, o_underflow=0, col=0, row=0, state IDLE.
REQ-030 SHALL NOT require line buffer contents to be reset; first EVEN row overwrites them.
REQ-031 SHALL, on rst asserted mid-frame, discard pipeline contents and stay IDLE after release until the next i_vsync falling edge.

Verification
REQ-032 SHALL pass: reset, vsync fall, i_next held 450 cycles, source returns 0x10,0x20,... -> o_src_req on even cols only (225 pulses), o_data 0x10,0x10,0x20,0x20... starting 2 cycles after first i_next.
REQ-033 SHALL pass: second row (row 1) with i_next 450 cycles -> zero o_src_req, o_data identical to row 0 sequence.
REQ-034 SHALL pass: i_next dropped 5 cycles at col 100 -> no output gap in sequence, col 100 pixel emitted after resume, o_valid low during gap (offset by 2).
REQ-035 SHALL pass: i_src_valid forced low for request at col 10 -> o_data 0 at cols 10 and 11, o_underflow=1 until next vsync fall, row 1 cols 10-11 also 0.
REQ-036 SHALL pass: full 450 rows then extra i_next -> state DONE, o_valid stays 0, no o_src_req; vsync fall mid-row 37 -> restart at col 0 row 0, coincident i_next produces no output.
REQ-037 SHALL pass: rst pulse mid-row -> outputs 0 within same cycle, i_next ignored until vsync fall.

Source files
------------

// File: rtl/pixel_upscale_2x.sv
// 2x nearest-neighbour upscaler: pulls one source pixel per output pair on even
// rows, buffers the line, and replays it from the line buffer on odd rows.
module pixel_upscale_2x #(
  parameter int unsigned SRC_W = 225,
  parameter int unsigned SRC_H = 225,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vsync,
  input  logic          i_next,
  output logic          o_src_req,
  input  logic [DW-1:0] i_src_data,
  input  logic          i_src_valid,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_underflow
);

  localparam int unsigned CW = $clog2(2 * SRC_W);
  localparam int unsigned RW = $clog2(2 * SRC_H);
  localparam int unsigned AW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(2 * SRC_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 * SRC_H - 1);

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          vsync_q, vsync_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_odd_row_q, s1_odd_row_d;
  logic          s1_col_odd_q, s1_col_odd_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0] pair_q, pair_d;
  logic [DW-1:0] o_data_q, o_data_d;
  logic          o_valid_q, o_valid_d;
  logic          uflow_q, uflow_d;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] mem [SRC_W];

  logic          vs_fall;
  logic          in_frame;
  logic          accept;
  logic          col_wrap;
  logic          mem_we;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] src_pix;
  logic [DW-1:0] pix;

  assign vs_fall  = vsync_q & ~i_vsync;
  assign col_wrap = (col_q == COL_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a vsync fall restarts the frame from any state
  always_comb begin
    state_d = state_q;
    if (vs_fall) begin
      state_d = EVEN;
    end else if (accept && col_wrap) begin
      case (state_q)
        EVEN:    state_d = ODD;
        ODD:     state_d = (row_q == ROW_LAST) ? DONE : EVEN;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: accept qualification and the combinational source pull
  always_comb begin
    in_frame  = (state_q == EVEN) || (state_q == ODD);
    accept    = i_next & in_frame & ~vs_fall;
    o_src_req = accept & (state_q == EVEN) & ~col_q[0];
  end

  // Output position counters
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (vs_fall) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Pipeline: stage 1 captures position, stage 2 registers the output pixel
  always_comb begin
    vsync_d      = i_vsync;
    rd_addr      = AW'(col_q >> 1);
    s1_valid_d   = accept;
    s1_odd_row_d = (state_q == ODD);
    s1_col_odd_d = col_q[0];
    s1_addr_d    = rd_addr;
    src_pix      = i_src_valid ? i_src_data : '0;
    mem_we       = s1_valid_q & ~s1_odd_row_q & ~s1_col_odd_q;
    pair_d       = mem_we ? src_pix : pair_q;
    pix          = s1_odd_row_q ? rd_q : (s1_col_odd_q ? pair_q : src_pix);
    o_valid_d    = s1_valid_q & ~vs_fall;
    o_data_d     = o_valid_d ? pix : '0;
    uflow_d      = uflow_q;
    if (vs_fall) uflow_d = 1'b0;
    else if (mem_we && !i_src_valid) uflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      vsync_q      <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_odd_row_q <= 1'b0;
      s1_col_odd_q <= 1'b0;
      s1_addr_q    <= '0;
      pair_q       <= '0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      uflow_q      <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      vsync_q      <= vsync_d;
      s1_valid_q   <= s1_valid_d;
      s1_odd_row_q <= s1_odd_row_d;
      s1_col_odd_q <= s1_col_odd_d;
      s1_addr_q    <= s1_addr_d;
      pair_q       <= pair_d;
      o_data_q     <= o_data_d;
      o_valid_q    <= o_valid_d;
      uflow_q      <= uflow_d;
    end
  end

  // Line buffer, no reset: every EVEN row rewrites it before the ODD row reads
  always_ff @(posedge clk) begin
    if (mem_we) mem[s1_addr_q] <= src_pix;
    rd_q <= mem[rd_addr];
  end

  assign o_data      = o_data_q;
  assign o_valid     = o_valid_q;
  assign o_underflow = uflow_q;

endmodule

// File: tb/tb_pixel_upscale_2x.sv
// Directed bench for pixel_upscale_2x on a reduced 8x4 source (16x8 output).
module tb_pixel_upscale_2x;

  localparam int SW = 8;
  localparam int SH = 4;

  logic       clk, rst, i_vsync, i_next, i_src_valid;
  logic [7:0] i_src_data;
  logic       o_src_req, o_valid, o_underflow;
  logic [7:0] o_data;

  pixel_upscale_2x #(.SRC_W(SW), .SRC_H(SH), .DW(8)) dut (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_next(i_next),
    .o_src_req(o_src_req), .i_src_data(i_src_data), .i_src_valid(i_src_valid),
    .o_data(o_data), .o_valid(o_valid), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  int         n_run, n_fail;
  int         b_col, b_row, src_idx;
  bit         active, prev_vs, e_under, pend, miss_pend;
  bit         d1_v, d2_v;
  logic [7:0] d1_d, d2_d, pend_val;
  bit         missed [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    active = 0; prev_vs = 1; e_under = 0; pend = 0; miss_pend = 0;
    d1_v = 0; d1_d = 8'h00; d2_v = 0; d2_d = 8'h00;
    b_col = 0; b_row = 0;
  endtask

  // One display cycle: drive inputs, compare outputs, advance the expectation model
  task automatic cyc(input bit nxt, input bit vs, input bit miss);
    bit         fall, acc;
    int         k, m;
    logic [7:0] pix;
    i_next      = nxt;
    i_vsync     = vs;
    i_src_valid = pend && !miss_pend;
    i_src_data  = !pend ? 8'h00 : (miss_pend ? 8'hEE : pend_val);
    #1;
    fall = prev_vs && !vs;
    acc  = nxt && active && !fall;
    check("valid", 32'(o_valid), 32'(d2_v));
    check("data", 32'(o_data), 32'(d2_d));
    check("src_req", 32'(o_src_req), 32'(acc && (b_row % 2 == 0) && (b_col % 2 == 0)));
    check("underflow", 32'(o_underflow), 32'(e_under));
    if (fall) e_under = 0;
    else if (pend && miss_pend) e_under = 1;
    if (fall) begin
      src_idx = 0;
      foreach (missed[i]) missed[i] = 0;
    end
    pend      = o_src_req;
    miss_pend = miss && o_src_req;
    if (o_src_req) begin
      pend_val = 8'(16 * ((src_idx % SW) + 1) + src_idx / SW);
      if (miss) missed[src_idx % 32] = 1;
      src_idx++;
    end
    k   = b_col / 2;
    m   = b_row / 2;
    pix = missed[(m * SW + k) % 32] ? 8'h00 : 8'(16 * (k + 1) + m);
    if (fall) begin
      d1_v = 0;
      d1_d = 8'h00;
    end
    d2_v = d1_v;
    d2_d = d1_d;
    d1_v = acc;
    d1_d = acc ? pix : 8'h00;
    if (fall) begin
      b_col = 0; b_row = 0; active = 1;
    end else if (acc) begin
      if (b_col == 2 * SW - 1) begin
        b_col = 0;
        if (b_row == 2 * SH - 1) begin
          b_row = 0; active = 0;
        end else begin
          b_row++;
        end
      end else begin
        b_col++;
      end
    end
    prev_vs = vs;
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 0; rst = 1; i_vsync = 1; i_next = 0; i_src_valid = 0; i_src_data = 8'h00;
    n_run = 0; n_fail = 0; src_idx = 0;
    foreach (missed[i]) missed[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(o_valid), 32'(0));
    check("reset_data", 32'(o_data), 32'(0));
    check("reset_req", 32'(o_src_req), 32'(0));
    check("reset_underflow", 32'(o_underflow), 32'(0));
    rst = 0;

    // Idle: i_next ignored until a vsync fall
    repeat (3) cyc(1, 1, 0);
    cyc(1, 0, 0);

    // Full frame: missing source pixel at col 4 of row 0, i_next gap at col 6
    for (int r = 0; r < 2 * SH; r++) begin
      for (int c = 0; c < 2 * SW; c++) begin
        if (r == 0 && c == 6) repeat (3) cyc(0, 1, 0);
        cyc(1, 1, (r == 0 && c == 4));
      end
    end
    repeat (2) cyc(0, 1, 0);
    repeat (4) cyc(1, 1, 0);

    // Second frame, restarted mid-row by a vsync fall with coincident i_next
    cyc(1, 0, 0);
    for (int n = 0; n < 3 * 2 * SW + 5; n++) cyc(1, 1, 0);
    cyc(1, 0, 0);
    for (int n = 0; n < 5; n++) cyc(1, 1, 0);

    // Asynchronous reset mid-row clears outputs immediately
    rst = 1;
    #1;
    check("midrst_valid", 32'(o_valid), 32'(0));
    check("midrst_data", 32'(o_data), 32'(0));
    check("midrst_req", 32'(o_src_req), 32'(0));
    check("midrst_underflow", 32'(o_underflow), 32'(0));
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    repeat (4) cyc(1, 1, 0);
    cyc(0, 0, 0);
    for (int n = 0; n < 2 * SW + 4; n++) cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
